// File: rtl/fifo_pkg.sv
// fifo_pkg: constants shared by the async-FIFO read side and its reader.
package fifo_pkg;
    localparam int RD_LATENCY = 1;
    localparam int BUF_DEPTH  = 3;
    localparam int DATA_WIDTH = 8;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'(BUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction
endpackage

// File: rtl/fifo_rd_buf.sv
// fifo_rd_buf: 3-entry in-order skid buffer holding words read from the FIFO.
module fifo_rd_buf
    import fifo_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [1:0]       occ
);
    logic [WIDTH-1:0] r_mem [BUF_DEPTH];
    logic [1:0]       r_wp;
    logic [1:0]       r_rp;
    logic [1:0]       r_occ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp  <= 2'd0;
            r_rp  <= 2'd0;
            r_occ <= 2'd0;
        end else begin
            if (wr_en) r_wp <= ptr_inc(r_wp);
            if (rd_en) r_rp <= ptr_inc(r_rp);
            r_occ <= r_occ + 2'(wr_en) - 2'(rd_en);
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) r_mem[r_wp] <= wr_data;
    end

    assign rd_data = r_mem[r_rp];
    assign occ     = r_occ;
endmodule

// File: rtl/fifo_reader.sv
// fifo_reader: drains an async FIFO read port into a valid/ready stream,
// requesting only when buffer space is guaranteed for every in-flight word.
module fifo_reader
    import fifo_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH,
    parameter int CNT_W = 16
) (
    input  logic             rd_clk,
    input  logic             rst,
    input  logic             fifo_empty,
    output logic             fifo_rd_req,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [CNT_W-1:0] word_count
);
    logic [RD_LATENCY-1:0] r_inflight;
    logic [CNT_W-1:0]      r_count;
    logic [1:0]            w_occ;
    logic                  w_pop;

    // Space is reserved for in-flight words, so m_ready never reaches the request.
    assign fifo_rd_req = !rst && !fifo_empty
                         && (int'(w_occ) + $countones(r_inflight) < BUF_DEPTH);
    assign m_valid     = !rst && (w_occ != 2'd0);
    assign w_pop       = m_valid && m_ready;
    assign word_count  = r_count;

    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            r_inflight <= '0;
            r_count    <= '0;
        end else begin
            r_inflight <= RD_LATENCY'({r_inflight, fifo_rd_req});
            if (w_pop) r_count <= r_count + CNT_W'(1);
        end
    end

    fifo_rd_buf #(.WIDTH(WIDTH)) u_buf (
        .clk     (rd_clk),
        .rst     (rst),
        .wr_en   (r_inflight[RD_LATENCY-1]),
        .wr_data (fifo_data),
        .rd_en   (w_pop),
        .rd_data (m_data),
        .occ     (w_occ)
    );
endmodule
